data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit memory words (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, wait cycles between request accept and response (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  CPU request present.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_size  input  2  access size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-009 SHALL have port req_unsigned  input  1  load zero-extends when 1 and sign-extends when 0.
REQ-010 SHALL have port req_addr  input  32  byte address.
REQ-011 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-012 SHALL have port rsp_valid  output  1  response present.
REQ-013 SHALL have port rsp_ready  input  1  CPU accepts response.
REQ-014 SHALL have port rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-015 SHALL have port rsp_err  output  1  misaligned or illegal-size access.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE; accept = req_valid && req_ready.
REQ-018 SHALL capture we/size/unsigned/addr/wdata into a request buffer on accept; later input changes have no effect.
REQ-019 SHALL go IDLE->WAIT on accept when LATENCY>0, loading the wait counter with LATENCY-1, and IDLE->RESP when LATENCY=0.
REQ-020 SHALL decrement the wait counter each WAIT cycle and go WAIT->RESP when the counter is 0.
REQ-021 SHALL assert rsp_valid exactly in RESP, first at cycle T+1+LATENCY for an accept at cycle T.
REQ-022 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1, then go RESP->IDLE.
REQ-023 SHALL NOT accept a new request in the cycle rsp_ready completes a response; minimum request spacing is LATENCY+2 cycles.
REQ-024 SHALL compute the word index as addr[log2(DEPTH_WORDS)+1:2], silently wrapping addresses beyond DEPTH_WORDS*4.
REQ-025 SHALL flag misalignment as half with addr[0]=1, word with addr[1:0]!=0, or size=11; rsp_err=1, no memory write, rsp_rdata=0.
REQ-026 SHALL commit a store on the transition into RESP, writing only the addressed byte lanes: byte lane addr[1:0], half lanes {addr[1],0}+1:0, word all lanes.
REQ-027 SHALL sample load data on the transition into RESP, shift the addressed lane to bit 0, and extend to 32 bits per size/unsigned.
REQ-028 SHALL return a load after a store to the same address with the post-store value.

Reset
REQ-029 SHALL, while rst=0, asynchronously force state IDLE, wait counter 0, rsp_valid=0, rsp_rdata=0, rsp_err=0 and req_ready=0.
REQ-030 SHALL drive req_ready=1 from the first clock edge after rst deasserts.
REQ-031 SHALL abandon any in-flight request when reset is asserted mid-operation, committing no write if reset lands in WAIT.
REQ-032 SHALL NOT clear memory array contents on reset.

Structure
REQ-033 SHALL place size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state encoding in shared package mem_pkg.
REQ-034 SHALL implement lane shift and sign/zero extension in one combinational sub-module, load_extend.
REQ-035 SHALL implement the memory as a synchronous-write register array with four byte-write enables.

Verification
REQ-036 SHALL check: LATENCY=2, store word 0xDEADBEEF @0x10 accepted at cycle 5 -> rsp_valid at cycle 8, err=0, rdata=0.
REQ-037 SHALL check: load byte signed @0x11 after REQ-036 -> rdata 0xFFFFFFBE; unsigned load -> 0x000000BE.
REQ-038 SHALL check: store half 0x1234 @0x12, then load word @0x10 -> 0x1234BEEF.
REQ-039 SHALL check: load word @0x02 -> err=1, rdata=0; store word @0x01 -> err=1, word @0x00 unchanged.
REQ-040 SHALL check: rsp_ready held 0 for 4 cycles -> rsp_valid/rdata stable and req_ready=0 throughout, with IDLE entered the cycle after rsp_ready=1.
REQ-041 SHALL check: rst pulled low during WAIT of a store 0x55 @0x20 -> outputs 0 immediately, and a later load @0x20 returns the old value.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings and small helpers for the data memory responder.
package mem_pkg;

    // Access size encodings carried on req_size.
    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    // Responder FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // True when the access cannot be served: unaligned half/word or illegal size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lsb[0];
            SZ_WORD: return |lsb;
            default: return 1'b1;
        endcase
    endfunction

    // Byte lanes touched by an aligned access of the given size.
    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            SZ_BYTE: return 4'b0001 << lsb;
            SZ_HALF: return lsb[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Moves the addressed byte/half lane down to bit 0 and sign- or zero-extends it.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  lane,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed lane and extend it to a full word.
    always_comb begin
        byte_sel = word[{lane, 3'b000} +: 8];
        half_sel = word[{lane[1], 4'b0000} +: 16];
        data     = '0;
        case (size)
            SZ_BYTE: data = is_unsigned ? {24'h000000, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: data = is_unsigned ? {16'h0000, half_sel} : {{16{half_sel[15]}}, half_sel};
            SZ_WORD: data = word;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder in front of a byte-lane-writable word memory.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t      state, next_state;
    logic [3:0]  wait_cnt;
    logic        ready_en;
    logic        accept;
    logic        enter_resp;

    logic        buf_we;
    logic [1:0]  buf_size;
    logic        buf_uns;
    logic [31:0] buf_addr;
    logic [31:0] buf_wdata;

    logic        cur_we;
    logic [1:0]  cur_size;
    logic        cur_uns;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] word_idx;
    logic          cur_err;
    logic [3:0]    byte_en;
    logic [31:0]   lane_wdata;
    logic [31:0]   rd_word;
    logic [31:0]   load_data;
    logic          unused_addr_bits;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= next_state;
    end

    // Holds req_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ready_en <= 1'b0;
        else      ready_en <= 1'b1;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        enter_resp = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = ready_en;
                if (req_valid && ready_en) begin
                    next_state = (LATENCY == 0) ? ST_RESP : ST_WAIT;
                    enter_resp = (LATENCY == 0);
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    next_state = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign accept = req_valid && req_ready;

    // Wait counter: loaded on accept, counts down while waiting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= 4'd0;
        end else if (accept && (LATENCY > 0)) begin
            wait_cnt <= 4'(LATENCY - 1);
        end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Request buffer captured on accept; later input changes are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_we    <= 1'b0;
            buf_size  <= SZ_BYTE;
            buf_uns   <= 1'b0;
            buf_addr  <= '0;
            buf_wdata <= '0;
        end else if (accept) begin
            buf_we    <= req_we;
            buf_size  <= req_size;
            buf_uns   <= req_unsigned;
            buf_addr  <= req_addr;
            buf_wdata <= req_wdata;
        end
    end

    // With zero latency the request is served in its accept cycle, straight from the inputs.
    assign cur_we    = (state == ST_IDLE) ? req_we       : buf_we;
    assign cur_size  = (state == ST_IDLE) ? req_size     : buf_size;
    assign cur_uns   = (state == ST_IDLE) ? req_unsigned : buf_uns;
    assign cur_addr  = (state == ST_IDLE) ? req_addr     : buf_addr;
    assign cur_wdata = (state == ST_IDLE) ? req_wdata    : buf_wdata;

    // Addresses beyond the array wrap; upper bits are intentionally ignored.
    assign word_idx         = cur_addr[AW+1:2];
    assign unused_addr_bits = ^cur_addr[31:AW+2];
    assign cur_err          = is_misaligned(cur_size, cur_addr[1:0]);
    assign byte_en          = lane_enables(cur_size, cur_addr[1:0]);
    assign rd_word          = mem[word_idx];

    // Replicate right-aligned store data across every lane it may land in.
    always_comb begin
        lane_wdata = cur_wdata;
        case (cur_size)
            SZ_BYTE: lane_wdata = {4{cur_wdata[7:0]}};
            SZ_HALF: lane_wdata = {2{cur_wdata[15:0]}};
            default: lane_wdata = cur_wdata;
        endcase
    end

    load_extend u_load_extend (
        .word       (rd_word),
        .size       (cur_size),
        .is_unsigned(cur_uns),
        .lane       (cur_addr[1:0]),
        .data       (load_data)
    );

    // Memory array: store committed on entry to RESP, contents survive reset.
    always_ff @(posedge clk) begin
        if (enter_resp && cur_we && !cur_err) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[word_idx][8*b +: 8] <= lane_wdata[8*b +: 8];
            end
        end
    end

    // Response registers, loaded on entry to RESP and held until the next response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (enter_resp) begin
            rsp_err   <= cur_err;
            rsp_rdata <= (cur_err || cur_we) ? '0 : load_data;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed table, corner sequences, random vs model.
module tb_data_mem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 256;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [7:0] mdl [DEPTH*4];

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [17];

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    // Byte-addressed memory model; returns the response a correct responder must give.
    function automatic void model(input logic we, input logic [1:0] sz, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  output logic err, output logic [31:0] rd);
        int n;
        int base;
        logic [31:0] v;
        err = (sz == 2'd3) || (sz == 2'd1 && addr % 2 != 0) || (sz == 2'd2 && addr % 4 != 0);
        rd  = 32'h0;
        if (err) return;
        n    = 1 << int'(sz);
        base = int'(addr % 32'(DEPTH*4));
        if (we) begin
            for (int i = 0; i < n; i++) mdl[base+i] = wd[8*i +: 8];
            return;
        end
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(mdl[base+i]) << (8*i));
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
        rd = v;
    endfunction

    // One complete transaction with latency, stability and handshake checks.
    task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic exp_err, input logic [31:0] exp_rd,
                       input int hold, input string tag);
        int t_acc;
        int t_rsp;
        int guard;
        logic [31:0] rd0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        guard = 0;
        while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
        if (!req_ready) chk({tag, " ready_timeout"}, 32'(req_ready), 32'h1);
        t_acc = cyc;
        @(posedge clk); #1;
        // Garbage on the request bus after accept must have no effect.
        req_we = 1'b0; req_size = 2'($urandom); req_unsigned = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        guard = 0;
        @(negedge clk);
        while (!rsp_valid && guard < 50) begin @(negedge clk); guard++; end
        t_rsp = cyc;
        chk({tag, " latency"}, 32'(t_rsp - t_acc), 32'(LAT + 1));
        chk({tag, " err"}, 32'(rsp_err), 32'(exp_err));
        chk({tag, " rdata"}, rsp_rdata, exp_rd);
        rd0 = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, " hold_valid"}, 32'(rsp_valid), 32'h1);
            chk({tag, " hold_rdata"}, rsp_rdata, rd0);
            chk({tag, " hold_ready"}, 32'(req_ready), 32'h0);
        end
        rsp_ready = 1'b1;
        chk({tag, " no_accept_on_complete"}, 32'(req_ready), 32'h0);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk({tag, " idle_valid"}, 32'(rsp_valid), 32'h0);
        chk({tag, " idle_ready"}, 32'(req_ready), 32'h1);
    endtask

    initial begin
        logic        e;
        logic [31:0] r;
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        int          guard;

        tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h00, 32'hCAFEF00D, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 2'd0, 1'b0, 32'h11, 32'h0,        1'b0, 32'hFFFFFFBE};
        tbl[4]  = '{1'b0, 2'd0, 1'b1, 32'h11, 32'h0,        1'b0, 32'h000000BE};
        tbl[5]  = '{1'b1, 2'd1, 1'b0, 32'h12, 32'h00001234, 1'b0, 32'h0};
        tbl[6]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        1'b0, 32'h1234BEEF};
        tbl[7]  = '{1'b0, 2'd2, 1'b0, 32'h02, 32'h0,        1'b1, 32'h0};
        tbl[8]  = '{1'b1, 2'd2, 1'b0, 32'h01, 32'hFFFFFFFF, 1'b1, 32'h0};
        tbl[9]  = '{1'b0, 2'd2, 1'b0, 32'h00, 32'h0,        1'b0, 32'hCAFEF00D};
        tbl[10] = '{1'b0, 2'd1, 1'b0, 32'h12, 32'h0,        1'b0, 32'h00001234};
        tbl[11] = '{1'b0, 2'd1, 1'b0, 32'h02, 32'h0,        1'b0, 32'hFFFFCAFE};
        tbl[12] = '{1'b0, 2'd1, 1'b1, 32'h02, 32'h0,        1'b0, 32'h0000CAFE};
        tbl[13] = '{1'b0, 2'd3, 1'b0, 32'h00, 32'h0,        1'b1, 32'h0};
        tbl[14] = '{1'b1, 2'd1, 1'b0, 32'h03, 32'h0000AAAA, 1'b1, 32'h0};
        tbl[15] = '{1'b0, 2'd2, 1'b0, 32'h410, 32'h0,       1'b0, 32'h1234BEEF};
        tbl[16] = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        1'b0, 32'h00000012};

        rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req_we = 1'b0;
        req_size = 2'd0; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst req_ready", 32'(req_ready), 32'h0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst rsp_rdata", rsp_rdata, 32'h0);
        chk("rst rsp_err", 32'(rsp_err), 32'h0);
        rst = 1'b1;
        #1 chk("release req_ready", 32'(req_ready), 32'h0);
        @(posedge clk); #1;
        chk("first_edge req_ready", 32'(req_ready), 32'h1);

        // Directed table.
        for (int i = 0; i < 17; i++) begin
            model(tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd, e, r);
            txn(tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd,
                tbl[i].exp_err, tbl[i].exp_rd, 0, $sformatf("vec%0d", i));
        end

        // Back-pressure: response held for 4 cycles.
        txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 32'h1234BEEF, 4, "hold4");

        // Reset lands while a byte store is waiting.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h55;
        guard = 0;
        while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst rsp_valid", 32'(rsp_valid), 32'h0);
        chk("midrst rsp_rdata", rsp_rdata, 32'h0);
        chk("midrst rsp_err", 32'(rsp_err), 32'h0);
        chk("midrst req_ready", 32'(req_ready), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst ready_back", 32'(req_ready), 32'h1);
        txn(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, 32'h11223344, 0, "after_midrst");

        // Initialise a 64-byte window, then random traffic inside it (with wrapped aliases).
        for (int w = 0; w < 16; w++) begin
            wd = $urandom;
            model(1'b1, 2'd2, 1'b0, 32'(w*4), wd, e, r);
            txn(1'b1, 2'd2, 1'b0, 32'(w*4), wd, e, r, 0, "fill");
        end
        for (int k = 0; k < 200; k++) begin
            we   = 1'($urandom);
            sz   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            uns  = 1'($urandom);
            addr = ($urandom & 32'hFFFFFC00) | 32'($urandom_range(0, 63));
            wd   = $urandom;
            model(we, sz, uns, addr, wd, e, r);
            txn(we, sz, uns, addr, wd, e, r, $urandom_range(0, 2), $sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
